riscv_test_monitor: RTL
=======================

// Module: riscv_test_monitor
// PURPOSE
//  Synthesizable end-of-test monitor sitting downstream of Core in the riscv-tests harness.
//  Consumes the fetch PC and register-writeback stream, shadows gp (x3), and detects test completion.
//  Produces sticky pass/fail/timeout status, failing test number and cycle count for the bench and
//  result-file writer. Replaces ad-hoc PC/register peeking in per-test benches.
// PARAMETERS
//  PASS_PC      32'h0000_0044  fetch address that marks end of test (pass/fail trap loop)
//  MAX_CYCLES   6000           cycles in RUN before timeout is declared
//  TOHOST_ADDR  32'h0000_1000  store address treated as tohost (used only with MONITOR_TOHOST_EN)
// PORTS
//  clk         in   1   core clock
//  rst         in   1   asynchronous, active-low reset
//  if_pc       in   32  fetch-stage PC
//  if_valid    in   1   if_pc holds a real fetch this cycle (not bubble/flush)
//  wb_we       in   1   register-file write enable at writeback
//  wb_rd       in   5   writeback destination register
//  wb_data     in   32  writeback data
//  mem_we      in   1   data-memory store strobe (used only with MONITOR_TOHOST_EN)
//  mem_addr    in   32  data-memory store address (used only with MONITOR_TOHOST_EN)
//  mem_wdata   in   32  data-memory store data (used only with MONITOR_TOHOST_EN)
//  done        out  1   test finished (any outcome); sticky
//  pass        out  1   finished and gp == 1; sticky
//  fail        out  1   finished and gp != 1; sticky
//  timeout     out  1   MAX_CYCLES reached without completion; sticky
//  test_num    out  31  gp[31:1] captured at completion (failing test number)
//  cycles      out  32  cycles spent in RUN; saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  - Reset (rst low, async): state=IDLE, gp shadow=0, all outputs 0.
//  - gp shadow: on wb_we && wb_rd==3, shadow <= wb_data. Writes to x0 and other registers ignored.
//  - Effective gp in a cycle = wb_data if (wb_we && wb_rd==3) that cycle, else shadow (same-cycle forward).
//  - FSM: IDLE -> RUN on first cycle with if_valid=1 (first cycle counts: cycles=1 the next edge).
//    RUN -> END on if_valid && if_pc==PASS_PC; END captures effective gp.
//    RUN -> TMO when cycles reaches MAX_CYCLES (counter==MAX_CYCLES-1 and incrementing).
//    END, TMO are terminal until reset; no further gp/cycle updates.
//  - Latency: outputs change on the clock edge that samples the completing condition (1-cycle, registered).
//  - END outputs: done=1; pass=(gp==1); fail=!pass; test_num=gp[31:1]. TMO: done=1, timeout=1, pass=fail=0.
//  - Simultaneous completion and timeout in the same cycle: completion wins, timeout stays 0.
//  - if_pc==PASS_PC with if_valid=0 (flushed slot) is ignored.
//  - Reset mid-run: immediate return to IDLE, counters/shadow cleared, new run on next if_valid.
//  - cycles counts in RUN only; frozen in END/TMO; saturates, never wraps.
// CONFIGURATION
//  MONITOR_TOHOST_EN defined: additional completion source in RUN: mem_we && mem_addr==TOHOST_ADDR
//    && mem_wdata!=0 -> END with gp replaced by mem_wdata (pass iff mem_wdata==1, test_num=mem_wdata[31:1]).
//    Same cycle as PC hit: tohost value takes precedence. Store of 0 ignored.
//  MONITOR_TOHOST_EN undefined: mem_* ports present but unused; only PC-based completion.
// TESTING
//  1 Reset, if_valid=1 at pc 0; wb x3<=1 at cycle 20; pc=0x44 valid at cycle 40 -> next edge done=1 pass=1 fail=0 cycles=40.
//  2 wb x3<=0x0000_0007, then pc=0x44 valid -> done=1 fail=1 pass=0 test_num=3.
//  3 wb x3<=1 and pc=0x44 valid in same cycle -> pass=1 (forwarded gp); repeat with x3<=5 same cycle -> fail=1 test_num=2.
//  4 Never hit PASS_PC, MAX_CYCLES=6000 -> timeout=1 done=1 at cycle 6000, pass=fail=0, cycles held at 6000.
//  5 pc=0x44 with if_valid=0 -> no change; then rst low mid-RUN -> all outputs 0 asynchronously, IDLE until next if_valid.
//  6 MONITOR_TOHOST_EN: store 0 to 0x1000 -> ignored; store 0x0000_000B to 0x1000 -> fail=1 test_num=5; store 1 -> pass=1.

Source files
------------

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: end-of-test monitor that shadows gp (x3), watches fetch PC / tohost and reports pass/fail/timeout.
// Latency: status registered, visible one edge after the completing condition is sampled.
// Backpressure: none; a passive observer that samples every cycle and never stalls the core.
// Optional feature macro: MONITOR_TOHOST_EN (adds tohost store as a second completion source).
module riscv_test_monitor #(
  parameter logic [31:0] PASS_PC     = 32'h0000_0044,
  parameter int unsigned MAX_CYCLES  = 6000,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] if_pc_i,
  input  logic        if_valid_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [30:0] test_num_o,
  output logic [31:0] cycles_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_END, S_TMO} state_e;

  localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] gp_q;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] result_q;

  logic        gp_wr;
  logic [31:0] eff_gp;
  logic        pc_hit;
  logic        tohost_hit;
  logic        complete;
  logic [31:0] cmp_val;
  logic        cyc_last;
  logic [31:0] cycles_inc;
  logic        live;

  // gp write detection and same-cycle forwarding so a write coinciding with completion is seen
  assign gp_wr  = wb_we_i && (wb_rd_i == 5'd3);
  assign eff_gp = gp_wr ? wb_data_i : gp_q;
  assign pc_hit = if_valid_i && (if_pc_i == PASS_PC);
  assign live   = (state_q == S_IDLE) || (state_q == S_RUN);

`ifdef MONITOR_TOHOST_EN
  // A nonzero store to tohost ends the test; its value overrides gp when both fire together
  assign tohost_hit = mem_we_i && (mem_addr_i == TOHOST_ADDR) && (mem_wdata_i != 32'd0);
  assign cmp_val    = tohost_hit ? mem_wdata_i : eff_gp;
`else
  // Store port is observed but has no effect in the PC-only build
  logic unused_mem;
  assign unused_mem = ^{mem_we_i, mem_addr_i, mem_wdata_i, TOHOST_ADDR};
  assign tohost_hit = 1'b0;
  assign cmp_val    = eff_gp;
`endif

  assign complete   = pc_hit || tohost_hit;
  assign cyc_last   = (cycles_q == LAST_CYCLE);
  assign cycles_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: completion is checked before timeout so it wins a same-cycle tie
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (if_valid_i) state_d = S_RUN;
      S_RUN: begin
        if (complete)      state_d = S_END;
        else if (cyc_last) state_d = S_TMO;
      end
      S_END:   state_d = S_END;
      S_TMO:   state_d = S_TMO;
      default: state_d = S_IDLE;
    endcase
  end

  // Cycle counter next value: the activating fetch counts as cycle 1, frozen once terminal
  always_comb begin
    cycles_d = cycles_q;
    if (state_q == S_IDLE && if_valid_i) begin
      cycles_d = 32'd1;
    end else if (state_q == S_RUN) begin
      cycles_d = cycles_inc;
    end
  end

  // Datapath registers: gp shadow, cycle count and the captured completion value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gp_q     <= 32'd0;
      cycles_q <= 32'd0;
      result_q <= 32'd0;
    end else begin
      if (live && gp_wr) gp_q <= wb_data_i;
      cycles_q <= cycles_d;
      if (state_q == S_RUN && complete) result_q <= cmp_val;
    end
  end

  // Outputs decoded from the terminal state and captured value
  always_comb begin
    done_o     = (state_q == S_END) || (state_q == S_TMO);
    timeout_o  = (state_q == S_TMO);
    pass_o     = (state_q == S_END) && (result_q == 32'd1);
    fail_o     = (state_q == S_END) && (result_q != 32'd1);
    test_num_o = (state_q == S_END) ? result_q[31:1] : 31'd0;
    cycles_o   = cycles_q;
  end

endmodule
